// File: rtl/isram_pkg.sv
// Shared types and constants for the instruction-SRAM AXI4-Lite read slave.
package isram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    MEM   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/isram_lfsr.sv
// 8-bit Fibonacci LFSR supplying the random access delay (ISRAM_RAND_DELAY_EN builds only).
module isram_lfsr
  import isram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [2:0] o_rnd
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = ^(r_lfsr & LFSR_TAPS);
  assign o_rnd = r_lfsr[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

endmodule

// File: rtl/isram_rd_slave.sv
// AXI4-Lite instruction read slave over a synchronous single-port SRAM.
// Optional feature macro: ISRAM_RAND_DELAY_EN (LFSR-driven access delay 0..7).
module isram_rd_slave
  import isram_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]   BASE        = 64'h8000_0000,
  parameter logic [ADDR_W-1:0]   SIZE_BYTES  = 64'h0800_0000,
  parameter int unsigned         FIXED_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_offset;
  logic              r_err;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_first;
  logic [3:0]        w_delay;
  logic              w_err;
  logic [ADDR_W:0]   w_addr_ext;
  logic [ADDR_W:0]   w_lo;
  logic [ADDR_W:0]   w_hi;

`ifdef ISRAM_RAND_DELAY_EN
  logic [2:0] w_rnd;

  isram_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (1'b1),
    .o_rnd (w_rnd)
  );

  assign w_delay = {1'b0, w_rnd};
`else
  assign w_delay = 4'(FIXED_DELAY);
`endif

  // Range compare one bit wider so BASE+SIZE_BYTES never wraps.
  assign w_addr_ext = {1'b0, s_araddr};
  assign w_lo       = {1'b0, BASE};
  assign w_hi       = {1'b0, BASE} + {1'b0, SIZE_BYTES};
  assign w_err      = (s_araddr[1:0] != 2'b00) || (w_addr_ext < w_lo) || (w_addr_ext >= w_hi);

  always_comb begin
    w_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = r_offset;
    s_rresp   = r_rresp;
    // Synchronous SRAM data arrives in the first RESP cycle; pass it through, then hold.
    s_rdata   = r_first ? mem_rdata : r_rdata;
    case (r_state)
      IDLE: begin
        s_arready = rst_n;
        if (s_arvalid) w_next = (w_delay != 4'd0) ? DELAY : MEM;
      end
      DELAY: begin
        if (r_cnt <= 4'd1) w_next = MEM;
      end
      MEM: begin
        mem_en = !r_err;
        w_next = RESP;
      end
      RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_offset <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_first  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (s_arvalid) begin
            r_offset <= s_araddr - BASE;
            r_err    <= w_err;
            r_cnt    <= w_delay;
          end
        end
        DELAY: r_cnt <= r_cnt - 4'd1;
        MEM: begin
          r_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
          r_first <= !r_err;
          if (r_err) r_rdata <= '0;
        end
        RESP: begin
          if (r_first) begin
            r_rdata <= mem_rdata;
            r_first <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isram_rd_slave.sv
// Self-checking bench for isram_rd_slave: transaction-level model plus directed and random fetches.
module tb_isram_rd_slave;

  localparam int unsigned FD   = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        mem_en;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  isram_rd_slave #(
    .ADDR_W      (64),
    .BASE        (BASE),
    .SIZE_BYTES  (SIZE),
    .FIXED_DELAY (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_araddr  (araddr),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_rdata   (rdata),
    .s_rresp   (rresp),
    .s_rvalid  (rvalid),
    .s_rready  (rready),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram(input logic [63:0] off);
    logic [31:0] lo;
    lo = off[31:0];
    return (lo * 32'h9E37_79B1) ^ 32'h0000_0413;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM: data valid the cycle after mem_en, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? sram(mem_addr) : $urandom;

  // Transaction-level reference: one outstanding fetch, timed from its AR cycle.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_t0 = 0;
  int          m_d = 0;
  logic [63:0] m_addr = '0;
  bit          m_err = 0;
  logic [7:0]  m_lfsr = 8'hA5;

  always @(negedge clk) begin
    int k;
    bit e_arready, e_memen, e_rvalid;
    k         = cyc - m_t0;
    e_arready = rst_n && !m_busy;
    e_memen   = m_busy && !m_err && (k == 1 + m_d);
    e_rvalid  = m_busy && (k >= 2 + m_d);
    chk("arready", {63'b0, arready}, {63'b0, e_arready});
    chk("mem_en",  {63'b0, mem_en},  {63'b0, e_memen});
    chk("rvalid",  {63'b0, rvalid},  {63'b0, e_rvalid});
    if (e_memen) chk("mem_addr", mem_addr, m_addr - BASE);
    if (e_rvalid) begin
      chk("rdata", {32'b0, rdata}, {32'b0, (m_err ? 32'h0 : sram(m_addr - BASE))});
      chk("rresp", {62'b0, rresp}, {62'b0, (m_err ? 2'b10 : 2'b00)});
    end
    if (!rst_n) begin
      m_busy = 0;
      m_lfsr = 8'hA5;
    end else begin
      if (!m_busy && arvalid) begin
        m_busy = 1;
        m_t0   = cyc;
        m_addr = araddr;
        m_err  = (araddr % 4 != 0) || (araddr < BASE) ||
                 ({1'b0, araddr} >= ({1'b0, BASE} + {1'b0, SIZE}));
`ifdef ISRAM_RAND_DELAY_EN
        m_d = int'(m_lfsr % 8);
`else
        m_d = FD;
`endif
      end else if (e_rvalid && rready) begin
        m_busy = 0;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    cyc++;
  end

  // Issue one fetch; caller sits just after a posedge. Returns cycle offsets from the AR cycle.
  task automatic fetch(input logic [63:0] a, input int stall,
                       output int lat_mem, output logic [63:0] maddr, output int lat_rv,
                       output logic [31:0] rd, output logic [1:0] rr);
    int n;
    bit got;
    lat_mem = -1; lat_rv = -1; maddr = '0; rd = '0; rr = '0;
    araddr  = a;
    arvalid = 1'b1;
    rready  = (stall == 0);
    got = 0;
    for (n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (arready) got = 1;
    end
    if (!got) begin
      chk("ar_timeout", 64'd1, 64'd0);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    got = 0;
    for (n = 1; n < 50 && !got; n++) begin
      @(negedge clk);
      if (mem_en) begin lat_mem = n; maddr = mem_addr; end
      if (rvalid) begin lat_rv = n; rd = rdata; rr = rresp; got = 1; end
    end
    if (!got) begin
      chk("r_timeout", 64'd1, 64'd0);
      return;
    end
    if (stall > 0) begin
      for (int i = 1; i < stall; i++) begin
        @(negedge clk);
        chk("stall_rvalid", {63'b0, rvalid}, 64'd1);
        chk("stall_rdata", {32'b0, rdata}, {32'b0, rd});
      end
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
      chk("hs_rvalid", {63'b0, rvalid}, 64'd1);
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      chk("idle_after_hs", {63'b0, arready}, 64'd1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lm, lr, gap, kind, st;
    logic [63:0] ma, a;
    logic [31:0] rd;
    logic [1:0]  rr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {63'b0, arready}, 64'd0);
    chk("rst_rvalid",  {63'b0, rvalid},  64'd0);
    chk("rst_rdata",   {32'b0, rdata},   64'd0);
    chk("rst_rresp",   {62'b0, rresp},   64'd0);
    chk("rst_mem_en",  {63'b0, mem_en},  64'd0);
    chk("rst_mem_addr", mem_addr,        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fetch(64'h8000_0000, 0, lm, ma, lr, rd, rr);
    chk("first_rdata", {32'b0, rd}, 64'h0000_0413);
    chk("first_rresp", {62'b0, rr}, 64'd0);
    chk("first_maddr", ma, 64'd0);

    fetch(64'h8000_0010, 0, lm, ma, lr, rd, rr);
    chk("d3_maddr", ma, 64'h10);
`ifndef ISRAM_RAND_DELAY_EN
    chk("d3_lat_mem", 64'(lm), 64'd4);
    chk("d3_lat_rv",  64'(lr), 64'd5);
`endif

    fetch(64'h8000_0002, 0, lm, ma, lr, rd, rr);
    chk("misal_no_mem", {63'b0, (lm >= 0)}, 64'd0);
    chk("misal_rresp", {62'b0, rr}, 64'h2);
    chk("misal_rdata", {32'b0, rd}, 64'd0);

    fetch(64'h7FFF_FFFC, 0, lm, ma, lr, rd, rr);
    chk("below_no_mem", {63'b0, (lm >= 0)}, 64'd0);
    chk("below_rresp", {62'b0, rr}, 64'h2);
    chk("below_rdata", {32'b0, rd}, 64'd0);

    fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, lm, ma, lr, rd, rr);
    chk("wrap_rresp", {62'b0, rr}, 64'h2);
    fetch(BASE + SIZE, 0, lm, ma, lr, rd, rr);
    chk("end_rresp", {62'b0, rr}, 64'h2);
    fetch(BASE + SIZE - 4, 0, lm, ma, lr, rd, rr);
    chk("last_rresp", {62'b0, rr}, 64'h0);

    fetch(64'h8000_0100, 5, lm, ma, lr, rd, rr);

    // Abort a fetch with reset right after acceptance.
    araddr  = 64'h8000_0040;
    arvalid = 1'b1;
    rready  = 1'b1;
    @(negedge clk);
    chk("abort_ar_ready", {63'b0, arready}, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {63'b0, arready}, 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_rvalid", {63'b0, rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    fetch(64'h8000_0040, 0, lm, ma, lr, rd, rr);
    chk("after_abort_rresp", {62'b0, rr}, 64'd0);
    chk("after_abort_maddr", ma, 64'h40);

    for (int t = 0; t < 100; t++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: a = BASE + 64'({$urandom_range(0, 32'h01FF_FFFF), 2'b00}) + 64'($urandom_range(1, 3));
        1: a = BASE - 64'({$urandom_range(1, 32'h0000_FFFF), 2'b00});
        2: a = BASE + SIZE + 64'({$urandom_range(0, 32'h0000_FFFF), 2'b00});
        default: a = BASE + 64'({$urandom_range(0, 32'h01FF_FFFF), 2'b00});
      endcase
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fetch(a, st, lm, ma, lr, rd, rr);
`ifdef ISRAM_RAND_DELAY_EN
      chk("rand_lat_range", {63'b0, (lr >= 2 && lr <= 9)}, 64'd1);
`else
      chk("fixed_lat", 64'(lr), 64'd5);
`endif
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
